// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU-control decoder plus a sequential multiply/divide unit that owns HI/LO.
// Multiply is shift-add and divide is restoring; both retire one bit per cycle.
module alu_ctrl_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic             ex_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Shared shift register: {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               div_q, div_d;
  logic               dz_q, dz_d;
  logic [5:0]         funct_q, funct_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic             rtype, is_md, is_hl, md_signed;
  logic             md_req, hl_use, issue, last_iter, same_insn;
  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] mag_a, mag_b, rem, quot;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  assign rtype     = (alu_op == 2'b10);
  assign is_md     = (funct[5:2] == 4'b0110);
  assign is_hl     = (funct == 6'b010000) || (funct == 6'b010010);
  assign md_signed = ~funct[0];

  assign md_req = ex_valid & ~flush & rtype & is_md;
  assign hl_use = (ex_valid & rtype & is_hl) | md_req;
  // A stalled mult/div stays in EX after finishing; done_q keeps it from re-issuing.
  assign issue  = md_req & ~done_q;

  assign sgn_a = md_signed & op_a[WIDTH-1];
  assign sgn_b = md_signed & op_b[WIDTH-1];
  assign mag_a = sgn_a ? -op_a : op_a;
  assign mag_b = sgn_b ? -op_b : op_b;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign same_insn = ex_valid & (funct == funct_q);

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q & {WIDTH{acc_q[0]}}};
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opd_q};
  assign rem       = acc_q[2*WIDTH-1:WIDTH];
  assign quot      = acc_q[WIDTH-1:0];

  // ALU code decode from main-control ALUOp and funct
  always_comb begin
    alu_ctrl = 4'b0000;
    case (alu_op)
      2'b00: alu_ctrl = 4'b0010;
      2'b01: alu_ctrl = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100100: alu_ctrl = 4'b0000;
          6'b100101: alu_ctrl = 4'b0001;
          6'b100000: alu_ctrl = 4'b0010;
          6'b100010: alu_ctrl = 4'b0110;
          6'b100111: alu_ctrl = 4'b1100;
          6'b101010: alu_ctrl = 4'b0111;
          6'b000000: alu_ctrl = 4'b1000;
          6'b000010: alu_ctrl = 4'b1001;
          6'b000011: alu_ctrl = 4'b1010;
          6'b100110: alu_ctrl = 4'b0100;
          6'b011000, 6'b011001: alu_ctrl = 4'b0101;
          6'b011010, 6'b011011: alu_ctrl = 4'b1011;
          default:   alu_ctrl = 4'b0000;
        endcase
      end
      default: alu_ctrl = 4'b0000;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush aborts any running operation
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       if (issue) state_d = funct[1] ? StDiv : StMul;
      StMul, StDiv: if (last_iter) state_d = StFix;
      StFix:        state_d = StIdle;
      default:      state_d = StIdle;
    endcase
    if (flush && (state_q != StIdle)) state_d = StIdle;
  end

  // FSM outputs; a squashed instruction never holds the pipeline
  always_comb begin
    busy  = (state_q != StIdle);
    stall = (busy & hl_use & ~flush) | (~busy & issue);
  end

  // Datapath next state: operand capture, iteration steps and sign fix-up
  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    div_d   = div_q;
    dz_d    = dz_q;
    funct_d = funct_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = done_q & same_insn;
    case (state_q)
      StIdle: begin
        if (issue) begin
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          opd_d   = mag_b;
          neg_a_d = sgn_a;
          neg_b_d = sgn_b;
          div_d   = funct[1];
          dz_d    = (op_b == '0);
          funct_d = funct;
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      StDiv: begin
        if (!div_diff[WIDTH]) begin
          acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
      end
      StFix: begin
        if (!flush) begin
          // Divide by zero leaves rem = |a|, which re-signs back to op_a.
          if (div_q) begin
            hi_d = neg_a_q ? -rem : rem;
            lo_d = dz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quot : quot);
          end else begin
            {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
          end
          done_d = same_insn;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      funct_q <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      funct_q <= funct_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
